aes_cbc_pkcs7_padder: RTL and testbench
=======================================

// Module: aes_cbc_pkcs7_padder
// PURPOSE
//  AXI-Stream stage sitting directly upstream of the AES-256-CBC iterative core.
//  Forwards the 48-byte header (32-byte key, then 16-byte IV) unchanged.
//  Forwards the message bytes and, for encryption, appends PKCS#7 padding so the
//  core always receives whole 16-byte blocks with tlast on the final block byte.
//  Decryption traffic passes through unchanged; bad lengths are flagged.
// PARAMETERS
//  AXIS_WIDTH    8   data width in bits on both ports; only 8 is supported (byte stream)
//  HEADER_BYTES  48  key bytes + IV bytes forwarded ahead of the payload
//  BLOCK_BYTES   16  AES block size in bytes; padding granularity
// PORTS
//  Clk           in   1              clock, all logic on rising edge
//  Rst           in   1              synchronous, active-high reset
//  S_axis        axis_if.slave  8    input stream: tdata/tkeep/tvalid/tready/tlast/tuser (tuser=1 encrypt)
//  M_axis        axis_if.master 8    output stream to the CBC core, same fields
//  Format_error  out  1              one-cycle pulse on a malformed packet
// BEHAVIOUR
//  Reset: state=ST_HEADER, all counters=0, encrypt_reg=0, Format_error=0, M_axis.tvalid=0.
//   With Rst high, S_axis.tready=0.
//  Pass-through (ST_HEADER, ST_PAYLOAD): zero latency, purely combinational.
//   M.tdata=S.tdata, M.tuser=S.tuser, M.tvalid=S.tvalid, S.tready=M.tready, M.tkeep=1.
//   A beat is accepted when S.tvalid & S.tready.
//  ST_HEADER:
//   - hdr_cnt counts accepted beats 0..HEADER_BYTES-1; M.tlast=0 except as noted below.
//   - Accepted beat at hdr_cnt=47 with tlast=0 -> ST_PAYLOAD; blk_cnt=0.
//   - Accepted beat at hdr_cnt=47 with tlast=1 and tuser=1 (empty message, encrypt):
//     forwarded with M.tlast=0; pad_val=16; -> ST_PAD.
//   - Accepted beat with tlast=1 otherwise (early tlast, or empty decrypt):
//     forwarded with M.tlast=1; Format_error pulses the next cycle; -> ST_HEADER; counters cleared.
//  ST_PAYLOAD:
//   - blk_cnt (4-bit) increments per accepted beat and wraps 15->0.
//   - encrypt_reg latches S.tuser on every accepted beat.
//   - Accepted tlast beat with tuser=1: forwarded with M.tlast=0;
//     pad_val = 16 - ((blk_cnt+1) mod 16), giving 1..16; -> ST_PAD.
//   - Accepted tlast beat with tuser=0: forwarded with M.tlast=1; -> ST_HEADER.
//     If blk_cnt != 15 on that beat, Format_error pulses the next cycle
//     (ciphertext not block aligned).
//  ST_PAD:
//   - S.tready=0.
//   - M.tvalid=1, M.tdata=pad_val, M.tuser=encrypt_reg, M.tkeep=1.
//   - pad_cnt counts from 1; M.tlast=1 when pad_cnt==pad_val.
//   - Advance only on M.tready; hold tdata/tlast stable while stalled.
//   - Last pad beat accepted -> ST_HEADER; counters cleared.
//  Output stalls (M.tready=0) never drop or duplicate bytes.
//  Reset asserted mid-packet aborts it immediately; no partial pad is emitted.
//  Format_error: registered, exactly 1 cycle wide, 0 in every other case.
// TESTING
//  T1 Encrypt, 48 header + 16 payload bytes (tlast on byte 16)
//     -> 80 output bytes; last 16 all 0x10; tlast only on byte 80.
//  T2 Encrypt, payload 5 bytes
//     -> 11 pad bytes of 0x0B; output total 64; tlast on final 0x0B; tuser=1 on all pad beats.
//  T3 Encrypt, empty payload (tlast on header byte 48)
//     -> 16 bytes of 0x10 follow the header; Format_error stays 0.
//  T4 Decrypt, 48 + 32 bytes -> bit-exact pass-through, tlast on byte 80, no error;
//     repeat with 48 + 20 bytes -> tlast forwarded on byte 68 and Format_error=1 for one cycle.
//  T5 Random M.tready stalls (50%) during T2 -> identical byte sequence; S.tready=0 throughout ST_PAD.
//  T6 Rst asserted at payload byte 3 -> next cycle M.tvalid=0, state ST_HEADER;
//     a new T1 packet then completes correctly.

Source files
------------

// File: rtl/aes_cbc_pkcs7_padder.sv
// AXI-Stream byte stage ahead of the AES-256-CBC core: forwards key/IV header and payload,
// appends PKCS#7 padding on encrypt traffic and flags malformed packet lengths.
module aes_cbc_pkcs7_padder #(
  parameter int unsigned AXIS_WIDTH   = 8,
  parameter int unsigned HEADER_BYTES = 48,
  parameter int unsigned BLOCK_BYTES  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [AXIS_WIDTH-1:0] S_axis_tdata,
  input  logic                  S_axis_tkeep,
  input  logic                  S_axis_tvalid,
  output logic                  S_axis_tready,
  input  logic                  S_axis_tlast,
  input  logic                  S_axis_tuser,
  output logic [AXIS_WIDTH-1:0] M_axis_tdata,
  output logic                  M_axis_tkeep,
  output logic                  M_axis_tvalid,
  input  logic                  M_axis_tready,
  output logic                  M_axis_tlast,
  output logic                  M_axis_tuser,
  output logic                  Format_error
);

  localparam int unsigned HW = $clog2(HEADER_BYTES);
  localparam int unsigned BW = $clog2(BLOCK_BYTES);
  localparam int unsigned PW = BW + 1;

  localparam logic [HW-1:0] HdrLast  = HW'(HEADER_BYTES - 1);
  localparam logic [BW-1:0] BlkLast  = BW'(BLOCK_BYTES - 1);
  localparam logic [PW-1:0] BlkBytes = PW'(BLOCK_BYTES);

  typedef enum logic [1:0] {StHeader, StPayload, StPad} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic [PW-1:0] pad_val_q, pad_val_d;
  logic [PW-1:0] pad_cnt_q, pad_cnt_d;
  logic          encrypt_q, encrypt_d;
  logic          fmt_err_q, fmt_err_d;
  logic          accept;
  logic          hdr_last_beat;

  assign accept        = S_axis_tvalid & S_axis_tready;
  assign hdr_last_beat = (hdr_cnt_q == HdrLast);
  assign Format_error  = fmt_err_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StHeader;
      hdr_cnt_q <= '0;
      blk_cnt_q <= '0;
      pad_val_q <= '0;
      pad_cnt_q <= '0;
      encrypt_q <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      pad_val_q <= pad_val_d;
      pad_cnt_q <= pad_cnt_d;
      encrypt_q <= encrypt_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    blk_cnt_d = blk_cnt_q;
    pad_val_d = pad_val_q;
    pad_cnt_d = pad_cnt_q;
    encrypt_d = encrypt_q;
    fmt_err_d = 1'b0;
    unique case (state_q)
      StHeader: begin
        if (accept) begin
          encrypt_d = S_axis_tuser;
          hdr_cnt_d = hdr_cnt_q + HW'(1);
          if (S_axis_tlast) begin
            hdr_cnt_d = '0;
            blk_cnt_d = '0;
            if (hdr_last_beat && S_axis_tuser) begin
              // Empty plaintext still gets one full pad block.
              pad_val_d = BlkBytes;
              pad_cnt_d = PW'(1);
              state_d   = StPad;
            end else begin
              fmt_err_d = 1'b1;
            end
          end else if (hdr_last_beat) begin
            hdr_cnt_d = '0;
            blk_cnt_d = '0;
            state_d   = StPayload;
          end
        end
      end
      StPayload: begin
        if (accept) begin
          encrypt_d = S_axis_tuser;
          blk_cnt_d = blk_cnt_q + BW'(1);
          if (S_axis_tlast) begin
            blk_cnt_d = '0;
            if (S_axis_tuser) begin
              // Bytes in the final block wrap to 0 when aligned, yielding a full pad block.
              pad_val_d = BlkBytes - {1'b0, blk_cnt_q + BW'(1)};
              pad_cnt_d = PW'(1);
              state_d   = StPad;
            end else begin
              fmt_err_d = (blk_cnt_q != BlkLast);
              state_d   = StHeader;
            end
          end
        end
      end
      StPad: begin
        if (M_axis_tready) begin
          if (pad_cnt_q == pad_val_q) begin
            pad_cnt_d = '0;
            pad_val_d = '0;
            blk_cnt_d = '0;
            hdr_cnt_d = '0;
            state_d   = StHeader;
          end else begin
            pad_cnt_d = pad_cnt_q + PW'(1);
          end
        end
      end
      default: state_d = StHeader;
    endcase
  end

  always_comb begin
    S_axis_tready = M_axis_tready & ~Rst;
    M_axis_tvalid = S_axis_tvalid & ~Rst;
    M_axis_tdata  = S_axis_tdata;
    M_axis_tuser  = S_axis_tuser;
    // Output is a dense byte stream; input tkeep carries no information here.
    M_axis_tkeep  = S_axis_tkeep | 1'b1;
    M_axis_tlast  = 1'b0;
    unique case (state_q)
      StHeader:  M_axis_tlast = S_axis_tlast & ~(hdr_last_beat & S_axis_tuser);
      StPayload: M_axis_tlast = S_axis_tlast & ~S_axis_tuser;
      StPad: begin
        S_axis_tready = 1'b0;
        M_axis_tvalid = ~Rst;
        M_axis_tdata  = {{(AXIS_WIDTH - PW){1'b0}}, pad_val_q};
        M_axis_tuser  = encrypt_q;
        M_axis_tlast  = (pad_cnt_q == pad_val_q);
      end
      default: M_axis_tlast = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_aes_cbc_pkcs7_padder.sv
// Directed bench for aes_cbc_pkcs7_padder: encrypt padding, decrypt pass-through,
// length errors, output stalls and mid-packet reset.
module tb_aes_cbc_pkcs7_padder;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] S_tdata;
  logic       S_tkeep, S_tvalid, S_tready, S_tlast, S_tuser;
  logic [7:0] M_tdata;
  logic       M_tkeep, M_tvalid, M_tlast, M_tuser;
  logic       M_tready = 1'b1;
  logic       Format_error;

  int vectors     = 0;
  int miscompares = 0;
  int timeouts    = 0;

  // Monitor-owned state.
  logic [7:0] out_d[$];
  bit         out_l[$];
  bit         out_u[$];
  int         err_cycles   = 0;
  int         keep_bad     = 0;
  int         lasts_seen   = 0;
  int         pad_rdy_viol = 0;

  // Stimulus-owned state.
  bit         stall_en = 1'b0;
  bit         in_pad   = 1'b0;
  int         pad_last_base = 0;
  logic [7:0] exp_d[$];

  always #5 Clk = ~Clk;

  aes_cbc_pkcs7_padder #(
    .AXIS_WIDTH  (8),
    .HEADER_BYTES(48),
    .BLOCK_BYTES (16)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .S_axis_tdata (S_tdata),
    .S_axis_tkeep (S_tkeep),
    .S_axis_tvalid(S_tvalid),
    .S_axis_tready(S_tready),
    .S_axis_tlast (S_tlast),
    .S_axis_tuser (S_tuser),
    .M_axis_tdata (M_tdata),
    .M_axis_tkeep (M_tkeep),
    .M_axis_tvalid(M_tvalid),
    .M_axis_tready(M_tready),
    .M_axis_tlast (M_tlast),
    .M_axis_tuser (M_tuser),
    .Format_error (Format_error)
  );

  always @(posedge Clk) begin
    #1;
    M_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge Clk) begin
    if (!Rst) begin
      if (in_pad && lasts_seen == pad_last_base && S_tready !== 1'b0) pad_rdy_viol++;
      if (Format_error === 1'b1) err_cycles++;
      if (M_tvalid === 1'b1 && M_tready) begin
        out_d.push_back(M_tdata);
        out_l.push_back(M_tlast);
        out_u.push_back(M_tuser);
        if (M_tkeep !== 1'b1) keep_bad++;
        if (M_tlast === 1'b1) lasts_seen++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input bit l, input bit u);
    bit acc = 1'b0;
    int guard = 0;
    S_tdata  = d;
    S_tlast  = l;
    S_tuser  = u;
    S_tvalid = 1'b1;
    do begin
      @(negedge Clk);
      acc = S_tready;
      @(posedge Clk);
      #1;
      guard++;
    end while (!acc && guard < 500);
    if (!acc) timeouts++;
    S_tvalid = 1'b0;
    S_tlast  = 1'b0;
  endtask

  task automatic run_pkt(input string tag, input int npay, input bit enc, input int seed,
                         input int exp_err);
    int base, ebase, total, guard, first_bad, nlast, last_pos, user_bad, pv;
    logic [7:0] d;
    base  = out_d.size();
    ebase = err_cycles;
    total = 48 + npay;
    exp_d.delete();
    for (int i = 0; i < total; i++) begin
      d = 8'((i * 37 + seed) & 255);
      exp_d.push_back(d);
      send_beat(d, i == total - 1, enc);
    end
    if (enc) begin
      pad_last_base = lasts_seen;
      in_pad = 1'b1;
      pv = 16 - (npay % 16);
      for (int i = 0; i < pv; i++) exp_d.push_back(8'(pv));
    end
    guard = 0;
    while ((out_d.size() - base) < exp_d.size() && guard < 3000) begin
      @(posedge Clk);
      guard++;
    end
    if (guard >= 3000) timeouts++;
    repeat (4) @(posedge Clk);
    #1;
    in_pad = 1'b0;
    chk({tag, " byte count"}, out_d.size() - base, exp_d.size());
    first_bad = -1;
    nlast = 0;
    last_pos = -1;
    user_bad = 0;
    for (int i = 0; i < exp_d.size() && base + i < out_d.size(); i++) begin
      if (first_bad < 0 && out_d[base + i] !== exp_d[i]) first_bad = i;
      if (out_l[base + i]) begin
        nlast++;
        if (last_pos < 0) last_pos = i;
      end
      if (out_u[base + i] != enc) user_bad++;
    end
    chk({tag, " first bad byte index"}, first_bad, -1);
    chk({tag, " tlast count"}, nlast, 1);
    chk({tag, " tlast position"}, last_pos, exp_d.size() - 1);
    chk({tag, " tuser wrong beats"}, user_bad, 0);
    chk({tag, " format_error cycles"}, err_cycles - ebase, exp_err);
  endtask

  initial begin
    int base;
    Rst      = 1'b1;
    S_tkeep  = 1'b1;
    S_tvalid = 1'b1;
    S_tdata  = 8'hAA;
    S_tlast  = 1'b0;
    S_tuser  = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset s_tready", S_tready, 0);
    chk("reset m_tvalid", M_tvalid, 0);
    chk("reset format_error", Format_error, 0);
    Rst      = 1'b0;
    S_tvalid = 1'b0;
    #1;
    chk("idle m_tvalid", M_tvalid, 0);
    @(posedge Clk);
    #1;

    run_pkt("T1 enc 16", 16, 1'b1, 3, 0);
    run_pkt("T2 enc 5", 5, 1'b1, 11, 0);
    run_pkt("T3 enc empty", 0, 1'b1, 29, 0);
    run_pkt("T4a dec 32", 32, 1'b0, 41, 0);
    run_pkt("T4b dec 20", 20, 1'b0, 53, 1);
    run_pkt("early tlast dec", -8, 1'b0, 61, 1);
    chk("pad s_tready low (no stalls)", pad_rdy_viol, 0);

    stall_en = 1'b1;
    run_pkt("T5 enc 5 stalled", 5, 1'b1, 11, 0);
    run_pkt("enc 31 stalled", 31, 1'b1, 77, 0);
    stall_en = 1'b0;
    @(posedge Clk);
    #1;
    chk("pad s_tready low (stalls)", pad_rdy_viol, 0);

    // Reset while the third payload byte is presented.
    base = out_d.size();
    for (int i = 0; i < 50; i++) send_beat(8'(i), 1'b0, 1'b1);
    S_tdata  = 8'h5C;
    S_tuser  = 1'b1;
    S_tvalid = 1'b1;
    Rst      = 1'b1;
    #1;
    chk("T6 rst s_tready", S_tready, 0);
    chk("T6 rst m_tvalid", M_tvalid, 0);
    @(posedge Clk);
    #1;
    Rst      = 1'b0;
    S_tvalid = 1'b0;
    #1;
    chk("T6 post-rst m_tvalid", M_tvalid, 0);
    repeat (20) @(posedge Clk);
    #1;
    chk("T6 bytes before abort", out_d.size() - base, 50);
    run_pkt("T6 T1 after rst", 16, 1'b1, 3, 0);

    chk("tkeep low beats", keep_bad, 0);
    chk("handshake timeouts", timeouts, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
